denise_collision: RTL and testbench

- Sprite/playfield collision detector downstream of the eight sprite shifters in Denise.
- Consumes each shifter's 2-bit serial output plus the 8 bitplane pixel bits, and evaluates collisions per pixel under CLXCON/CLXCON2 control.
- Accumulates sticky collision flags and presents them as CLXDAT on the register read bus; a read clears them.

---
 rtl/denise_pkg.sv | 25 ++
 rtl/denise_collision_eval.sv | 44 ++++
 rtl/denise_collision.sv | 88 ++++++++
 tb/tb_denise_collision.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/denise_pkg.sv
// Shared constants for the Denise collision detector: register addresses and
// CLXDAT bit positions.
package denise_pkg;

  localparam logic [8:1] CLXDAT_ADR  = 8'h07;
  localparam logic [8:1] CLXCON_ADR  = 8'h4C;
  localparam logic [8:1] CLXCON2_ADR = 8'h87;

  localparam int unsigned CLX_EVEN_ODD = 0;
  localparam int unsigned CLX_ODD_S0   = 1;
  localparam int unsigned CLX_ODD_S1   = 2;
  localparam int unsigned CLX_ODD_S2   = 3;
  localparam int unsigned CLX_ODD_S3   = 4;
  localparam int unsigned CLX_EVEN_S0  = 5;
  localparam int unsigned CLX_EVEN_S1  = 6;
  localparam int unsigned CLX_EVEN_S2  = 7;
  localparam int unsigned CLX_EVEN_S3  = 8;
  localparam int unsigned CLX_S0_S1    = 9;
  localparam int unsigned CLX_S0_S2    = 10;
  localparam int unsigned CLX_S0_S3    = 11;
  localparam int unsigned CLX_S1_S2    = 12;
  localparam int unsigned CLX_S1_S3    = 13;
  localparam int unsigned CLX_S2_S3    = 14;

endpackage

// File: rtl/denise_collision_eval.sv
// Combinational per-pixel collision evaluation: bitplane match against CLXCON
// enables/values and sprite-group overlap.
module denise_collision_eval
  import denise_pkg::*;
(
  input  logic [7:0]  bpldata_i,
  input  logic [15:0] sprdata_i,
  input  logic [3:0]  ensp_i,
  input  logic [7:0]  enbp_i,
  input  logic [7:0]  mvbp_i,
  output logic [14:0] clx_o
);

  logic [7:0] match;
  logic       odd;
  logic       even;
  logic [3:0] sg;

  always_comb begin
    match = ~enbp_i | ~(bpldata_i ^ mvbp_i);
    // Plane 1 is bit 0, so "odd" planes sit on even indices.
    odd   = match[0] & match[2] & match[4] & match[6];
    even  = match[1] & match[3] & match[5] & match[7];

    sg = '0;
    for (int g = 0; g < 4; g++) begin
      sg[g] = (|sprdata_i[4*g +: 2]) | (ensp_i[g] & (|sprdata_i[4*g+2 +: 2]));
    end

    clx_o = '0;
    clx_o[CLX_EVEN_ODD] = even & odd;
    for (int g = 0; g < 4; g++) begin
      clx_o[CLX_ODD_S0 + g]  = odd & sg[g];
      clx_o[CLX_EVEN_S0 + g] = even & sg[g];
    end
    clx_o[CLX_S0_S1] = sg[0] & sg[1];
    clx_o[CLX_S0_S2] = sg[0] & sg[2];
    clx_o[CLX_S0_S3] = sg[0] & sg[3];
    clx_o[CLX_S1_S2] = sg[1] & sg[2];
    clx_o[CLX_S1_S3] = sg[1] & sg[3];
    clx_o[CLX_S2_S3] = sg[2] & sg[3];
  end

endmodule

// File: rtl/denise_collision.sv
// Denise sprite/playfield collision detector: two-stage pixel pipeline feeding
// sticky CLXDAT flags that clear on read.
module denise_collision
  import denise_pkg::*;
#(
  parameter bit AGA = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic        pix_en,
  input  logic        disp_win,
  input  logic [8:1]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  bpldata,
  input  logic [15:0] sprdata,
  output logic [15:0] data_out
);

  logic [3:0]  ensp_q, ensp_d;
  logic [7:0]  enbp_q, enbp_d;
  logic [7:0]  mvbp_q, mvbp_d;
  logic [7:0]  bpl_q;
  logic [15:0] spr_q;
  logic        vld_q;
  logic [14:0] clx_q, clx_d;
  logic [14:0] c;
  logic [14:0] hit;
  logic        clxcon_wr;
  logic        clxcon2_wr;
  logic        clx_rd;

  denise_collision_eval u_eval (
    .bpldata_i (bpl_q),
    .sprdata_i (spr_q),
    .ensp_i    (ensp_q),
    .enbp_i    (enbp_q),
    .mvbp_i    (mvbp_q),
    .clx_o     (c)
  );

  always_comb begin
    clxcon_wr  = clk7_en & wr & (reg_address_in == CLXCON_ADR);
    clxcon2_wr = clk7_en & wr & (reg_address_in == CLXCON2_ADR) & AGA;
    clx_rd     = clk7_en & rd & (reg_address_in == CLXDAT_ADR);

    ensp_d = ensp_q;
    enbp_d = enbp_q;
    mvbp_d = mvbp_q;
    if (clxcon_wr) begin
      ensp_d = data_in[15:12];
      enbp_d = {2'b00, data_in[11:6]};
      mvbp_d = {2'b00, data_in[5:0]};
    end else if (clxcon2_wr) begin
      enbp_d[7:6] = data_in[7:6];
      mvbp_d[7:6] = data_in[1:0];
    end

    hit = vld_q ? c : '0;
    // Clear-then-set so a collision landing on the read edge survives.
    clx_d = clx_rd ? hit : (clx_q | hit);

    data_out = (clx_rd && reset_n) ? {1'b1, clx_q} : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ensp_q <= '0;
      enbp_q <= '0;
      mvbp_q <= '0;
      bpl_q  <= '0;
      spr_q  <= '0;
      vld_q  <= 1'b0;
      clx_q  <= '0;
    end else begin
      ensp_q <= ensp_d;
      enbp_q <= enbp_d;
      mvbp_q <= mvbp_d;
      bpl_q  <= bpldata;
      spr_q  <= sprdata;
      vld_q  <= pix_en & disp_win;
      clx_q  <= clx_d;
    end
  end

endmodule

// File: tb/tb_denise_collision.sv
// Directed bench for denise_collision with a reference collision model and a
// queue of expected CLXDAT reads.
module tb_denise_collision;

  localparam logic [7:0] ADR_CLXDAT  = 8'h07;
  localparam logic [7:0] ADR_CLXCON  = 8'h4C;
  localparam logic [7:0] ADR_CLXCON2 = 8'h87;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk7_en = 1'b0;
  logic        pix_en = 1'b0;
  logic        disp_win = 1'b0;
  logic [7:0]  reg_address_in = '0;
  logic [15:0] data_in = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  bpldata = '0;
  logic [15:0] sprdata = '0;
  logic [15:0] data_out;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [3:0]  m_ensp = '0;
  logic [7:0]  m_enbp = '0;
  logic [7:0]  m_mvbp = '0;
  logic [14:0] m_clx = '0;
  logic [15:0] exp_q[$];

  denise_collision #(.AGA(1'b1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk7_en        (clk7_en),
    .pix_en         (pix_en),
    .disp_win       (disp_win),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .rd             (rd),
    .wr             (wr),
    .bpldata        (bpldata),
    .sprdata        (sprdata),
    .data_out       (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] model_c(input logic [7:0] bpl, input logic [15:0] spr);
    logic        odd = 1'b1;
    logic        even = 1'b1;
    logic [3:0]  sg = '0;
    logic [14:0] r = '0;
    int          k = 9;
    for (int i = 0; i < 8; i++) begin
      if (m_enbp[i] && (bpl[i] != m_mvbp[i])) begin
        if (i % 2 == 0) odd = 1'b0;
        else            even = 1'b0;
      end
    end
    for (int g = 0; g < 4; g++) begin
      sg[g] = (spr[4*g +: 2] != 2'b00) || (m_ensp[g] && (spr[4*g+2 +: 2] != 2'b00));
    end
    r[0] = even && odd;
    for (int g = 0; g < 4; g++) begin
      r[1+g] = odd && sg[g];
      r[5+g] = even && sg[g];
    end
    for (int a = 0; a < 4; a++) begin
      for (int b = a + 1; b < 4; b++) begin
        r[k] = sg[a] && sg[b];
        k++;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%04h want 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [7:0] adr, input logic [15:0] d);
    @(negedge clk);
    reg_address_in = adr;
    data_in = d;
    wr = 1'b1;
    clk7_en = 1'b1;
    if (adr == ADR_CLXCON) begin
      m_ensp = d[15:12];
      m_enbp = {2'b00, d[11:6]};
      m_mvbp = {2'b00, d[5:0]};
    end else if (adr == ADR_CLXCON2) begin
      m_enbp[7:6] = d[7:6];
      m_mvbp[7:6] = d[1:0];
    end
    @(negedge clk);
    wr = 1'b0;
    clk7_en = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] bpl, input logic [15:0] spr, input logic disp);
    @(negedge clk);
    bpldata = bpl;
    sprdata = spr;
    pix_en = 1'b1;
    disp_win = disp;
    if (disp) m_clx = m_clx | model_c(bpl, spr);
    @(negedge clk);
    bpldata = '0;
    sprdata = '0;
    pix_en = 1'b0;
    disp_win = 1'b0;
  endtask

  task automatic read_clx(input string tag);
    @(negedge clk);
    reg_address_in = ADR_CLXDAT;
    rd = 1'b1;
    clk7_en = 1'b1;
    exp_q.push_back({1'b1, m_clx});
    #1;
    check(tag, data_out, exp_q.pop_front());
    m_clx = '0;
    @(posedge clk);
    #1;
    rd = 1'b0;
    clk7_en = 1'b0;
  endtask

  initial begin
    logic [14:0] c_new;
    #12;
    reset_n = 1'b1;

    // Reset state and idle bus.
    @(negedge clk);
    check("idle_out", data_out, 16'h0000);
    read_clx("reset_read");

    // Sprites 0 and 2 overlap with all planes disabled.
    write_reg(ADR_CLXCON, 16'h0000);
    pixel(8'h00, 16'h0021, 1'b1);
    read_clx("spr0_spr2");
    read_clx("clear_after_read");

    // Plane 1 enabled and matched / mismatched against sprite 4.
    write_reg(ADR_CLXCON, 16'h0041);
    pixel(8'h01, 16'h0300, 1'b1);
    read_clx("plane1_match");
    pixel(8'h00, 16'h0300, 1'b1);
    read_clx("plane1_mismatch");

    // Attached odd sprite counts only when its ensp bit is set.
    write_reg(ADR_CLXCON, 16'h1000);
    pixel(8'h00, 16'h0004, 1'b1);
    read_clx("attach_on");
    write_reg(ADR_CLXCON, 16'h0000);
    pixel(8'h00, 16'h0004, 1'b1);
    read_clx("attach_off");

    // Plane 7 via CLXCON2, then cleared again by a CLXCON write.
    write_reg(ADR_CLXCON2, 16'h0041);
    pixel(8'h40, 16'h1000, 1'b1);
    read_clx("plane7_match");
    pixel(8'h00, 16'h1000, 1'b1);
    read_clx("plane7_mismatch");
    write_reg(ADR_CLXCON, 16'h0000);
    pixel(8'h00, 16'h1000, 1'b1);
    read_clx("plane7_cleared");

    // Read on the same edge a new collision reaches stage 2.
    pixel(8'h00, 16'h0001, 1'b1);
    @(negedge clk);
    bpldata = 8'h00;
    sprdata = 16'h0010;
    pix_en = 1'b1;
    disp_win = 1'b1;
    c_new = model_c(8'h00, 16'h0010);
    @(negedge clk);
    pix_en = 1'b0;
    disp_win = 1'b0;
    sprdata = '0;
    reg_address_in = ADR_CLXDAT;
    rd = 1'b1;
    clk7_en = 1'b1;
    exp_q.push_back({1'b1, m_clx});
    #1;
    check("coincident_old", data_out, exp_q.pop_front());
    m_clx = c_new;
    @(posedge clk);
    #1;
    rd = 1'b0;
    clk7_en = 1'b0;
    read_clx("coincident_kept");

    // Outside the display window nothing is recorded.
    pixel(8'h00, 16'hFFFF, 1'b0);
    read_clx("disp_win_low");

    // Non-CLXDAT reads and reads without clk7_en return zero.
    pixel(8'h00, 16'h0001, 1'b1);
    @(negedge clk);
    reg_address_in = ADR_CLXCON;
    rd = 1'b1;
    clk7_en = 1'b1;
    #1;
    check("rd_other_addr", data_out, 16'h0000);
    @(negedge clk);
    reg_address_in = ADR_CLXDAT;
    clk7_en = 1'b0;
    #1;
    check("rd_no_clk7", data_out, 16'h0000);
    @(negedge clk);
    rd = 1'b0;
    read_clx("flags_survive");

    // Asynchronous reset mid-accumulation.
    pixel(8'h00, 16'hFFFF, 1'b1);
    @(negedge clk);
    check("full_accum", {1'b0, dut.clx_q}, {1'b0, m_clx});
    reg_address_in = ADR_CLXDAT;
    rd = 1'b1;
    clk7_en = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_clear", {1'b0, dut.clx_q}, 16'h0000);
    check("out_in_reset", data_out, 16'h0000);
    m_clx = '0;
    m_ensp = '0;
    m_enbp = '0;
    m_mvbp = '0;
    @(negedge clk);
    rd = 1'b0;
    clk7_en = 1'b0;
    reset_n = 1'b1;
    read_clx("read_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
